// File: rtl/rob_top.sv
// Reorder buffer core for the RV32IM out-of-order pipeline.
//
// A 32-entry circular queue. Issue allocates the tail entry and records the
// destination architectural register; result broadcasts fill entries out of
// order; the head entry retires onto the regfile write bus as soon as it is
// both allocated and completed, one entry per cycle, strictly in order.
//
// Ports:
//   clk              clock, rising edge
//   rst              synchronous reset, active low
//   issue            allocate the tail entry this cycle (ignored while full)
//   DR_entry_issue   destination architectural register of the issued instr
//   bus[]            result broadcasts: valid, dest_rob, value
//   cir_q_full       all entries allocated
//   cir_q_empty      no entries allocated
//   rob_regfile_bus  registered commit write: valid, value, rob_idx, regfile_idx

package rv_structs;
  typedef struct packed {
    logic        valid;
    logic [4:0]  dest_rob;
    logic [31:0] value;
  } data_bus;
endpackage

package rob_entry_structs;
  typedef struct packed {
    logic        valid;
    logic [31:0] value;
    logic [4:0]  rob_idx;
    logic [4:0]  regfile_idx;
  } rob_to_regfile;
endpackage

module rob_top #(
  parameter int DEPTH   = 32,
  parameter int NUM_BUS = 5,
  parameter int XLEN    = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             issue,
  input  logic [4:0]                       DR_entry_issue,
  input  rv_structs::data_bus              bus [0:NUM_BUS-1],
  output logic                             cir_q_full,
  output logic                             cir_q_empty,
  output rob_entry_structs::rob_to_regfile rob_regfile_bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] FULL_CNT = DEPTH[IDX_W:0];

  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [IDX_W:0]   count;
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] ready;
  logic [4:0]       entry_rf    [DEPTH];
  logic [XLEN-1:0]  entry_value [DEPTH];

  logic               do_issue;
  logic               do_commit;
  logic [NUM_BUS-1:0] bc_ok;

  assign cir_q_empty = (count == '0);
  assign cir_q_full  = (count == FULL_CNT);

  // Every decision uses pre-edge state: an issue while full is rejected even
  // if the head commits in the same cycle, a broadcast to the entry being
  // issued misses because it is not busy yet, and a broadcast to the head
  // only makes it commit on the following edge.
  assign do_issue  = issue & ~cir_q_full;
  assign do_commit = busy[head] & ready[head];

  always_comb begin
    bc_ok = '0;
    for (int k = 0; k < NUM_BUS; k++) begin
      bc_ok[k] = bus[k].valid & busy[bus[k].dest_rob] & ~ready[bus[k].dest_rob];
    end
  end

  // Control state: pointers, occupancy, per-entry busy/ready, commit bus
  always_ff @(posedge clk) begin
    if (!rst) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      busy            <= '0;
      ready           <= '0;
      rob_regfile_bus <= '0;
    end else begin
      // Commit, issue and broadcast never touch the same entry in one cycle:
      // the committing head is already ready, the issued tail is not busy.
      for (int k = 0; k < NUM_BUS; k++) begin
        if (bc_ok[k]) ready[bus[k].dest_rob] <= 1'b1;
      end

      rob_regfile_bus.valid <= do_commit;
      if (do_commit) begin
        rob_regfile_bus.value       <= entry_value[head];
        rob_regfile_bus.rob_idx     <= head;
        rob_regfile_bus.regfile_idx <= entry_rf[head];
        busy[head]                  <= 1'b0;
        ready[head]                 <= 1'b0;
        head                        <= head + IDX_W'(1);
      end

      if (do_issue) begin
        busy[tail]  <= 1'b1;
        ready[tail] <= 1'b0;
        tail        <= tail + IDX_W'(1);
      end

      case ({do_issue, do_commit})
        2'b10:   count <= count + (IDX_W+1)'(1);
        2'b01:   count <= count - (IDX_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry payload: written only where the control path says so
  always_ff @(posedge clk) begin
    if (rst && do_issue) entry_rf[tail] <= DR_entry_issue;
    // Walk from the highest bus down so the lowest-indexed bus lands last
    // and wins when several buses hit the same entry.
    for (int k = NUM_BUS-1; k >= 0; k--) begin
      if (rst && bc_ok[k]) entry_value[bus[k].dest_rob] <= bus[k].value;
    end
  end

endmodule

// File: tb/tb_rob_top.sv
// Testbench for rob_top: directed scenario (fill, drain, wrap, out-of-order
// completion) followed by randomized issue/broadcast/reset traffic, all
// checked every cycle against a queue-based reference model.
//
// Ports: drives every rob_top input, observes every output.

module tb_rob_top;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                             rst;
  logic                             issue;
  logic [4:0]                       dr;
  rv_structs::data_bus              bus [0:4];
  logic                             cir_q_full;
  logic                             cir_q_empty;
  rob_entry_structs::rob_to_regfile rob_regfile_bus;

  rob_top #(.DEPTH(32), .NUM_BUS(5), .XLEN(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .issue           (issue),
    .DR_entry_issue  (dr),
    .bus             (bus),
    .cir_q_full      (cir_q_full),
    .cir_q_empty     (cir_q_empty),
    .rob_regfile_bus (rob_regfile_bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: allocation order is a queue of entry numbers; each entry
  // remembers its destination register, completion flag and result.
  int          q[$];
  bit          rdy  [32];
  logic [31:0] mval [32];
  logic [4:0]  mdr  [32];
  int          mtail;
  logic        exp_valid;
  logic [31:0] exp_value;
  logic [4:0]  exp_rob;
  logic [4:0]  exp_rf;

  function automatic bit allocated(input int d);
    foreach (q[i]) if (q[i] == d) return 1'b1;
    return 1'b0;
  endfunction

  // Predict the edge from the current inputs, advance one clock, compare.
  task automatic step();
    bit          commit_now;
    bit          issue_ok;
    bit          hit [32];
    logic [31:0] hv  [32];
    int          h;
    for (int e = 0; e < 32; e++) begin hit[e] = 1'b0; hv[e] = '0; end
    if (rst === 1'b0) begin
      q.delete();
      for (int e = 0; e < 32; e++) rdy[e] = 1'b0;
      mtail = 0;
      exp_valid = 1'b0; exp_value = '0; exp_rob = '0; exp_rf = '0;
    end else begin
      commit_now = (q.size() > 0) && rdy[q[0]];
      issue_ok   = issue && (q.size() < 32);
      for (int k = 0; k < 5; k++) begin
        if (bus[k].valid) begin
          int d;
          d = int'(bus[k].dest_rob);
          if (allocated(d) && !rdy[d] && !hit[d]) begin
            hit[d] = 1'b1;
            hv[d]  = bus[k].value;
          end
        end
      end
      exp_valid = commit_now;
      if (commit_now) begin
        h = q.pop_front();
        exp_value = mval[h];
        exp_rob   = h[4:0];
        exp_rf    = mdr[h];
        rdy[h]    = 1'b0;
      end
      for (int e = 0; e < 32; e++) begin
        if (hit[e]) begin rdy[e] = 1'b1; mval[e] = hv[e]; end
      end
      if (issue_ok) begin
        q.push_back(mtail);
        mdr[mtail] = dr;
        rdy[mtail] = 1'b0;
        mtail = (mtail + 1) % 32;
      end
    end
    @(posedge clk);
    #1;
    check_eq("empty",   32'(cir_q_empty),                 32'(q.size() == 0));
    check_eq("full",    32'(cir_q_full),                  32'(q.size() == 32));
    check_eq("valid",   32'(rob_regfile_bus.valid),       32'(exp_valid));
    check_eq("value",   rob_regfile_bus.value,            exp_value);
    check_eq("rob_idx", 32'(rob_regfile_bus.rob_idx),     32'(exp_rob));
    check_eq("rf_idx",  32'(rob_regfile_bus.regfile_idx), 32'(exp_rf));
  endtask

  task automatic clr_bus();
    for (int k = 0; k < 5; k++) bus[k] = '0;
  endtask

  task automatic put(input int k, input int idx, input int val);
    bus[k].valid    = 1'b1;
    bus[k].dest_rob = idx[4:0];
    bus[k].value    = val[31:0];
  endtask

  int g1 [5] = '{31, 1, 16, 20, 23};
  int g2 [5] = '{15, 21, 18, 22, 25};
  int g3 [5] = '{26, 29, 30, 28, 27};
  int g4 [3] = '{17, 19, 24};
  int o1 [5] = '{8, 14, 7, 12, 5};
  int o2 [5] = '{6, 9, 11, 13, 10};

  initial begin
    rst = 1'b0; issue = 1'b0; dr = '0;
    clr_bus();
    repeat (5) step();
    rst = 1'b1;
    step();
    check_eq("reset_empty", 32'(cir_q_empty), 32'd1);
    check_eq("reset_full",  32'(cir_q_full),  32'd0);
    check_eq("reset_valid", 32'(rob_regfile_bus.valid), 32'd0);

    // Fill, one issue every other cycle
    for (int i = 0; i < 32; i++) begin
      issue = 1'b1; dr = 5'(i);
      step();
      issue = 1'b0;
      step();
    end
    check_eq("fill_full",  32'(cir_q_full),  32'd1);
    check_eq("fill_empty", 32'(cir_q_empty), 32'd0);

    // In-order drain of entries 0..4
    for (int i = 0; i < 5; i++) begin
      clr_bus();
      put(i, i, 200 + i);
      step();
    end
    clr_bus();
    repeat (3) step();
    check_eq("drain_full",  32'(cir_q_full),  32'd0);
    check_eq("drain_empty", 32'(cir_q_empty), 32'd0);

    // Wrap: reallocate entries 0..4, then one issue while full
    for (int i = 0; i < 5; i++) begin
      issue = 1'b1; dr = 5'(20 + i);
      step();
    end
    check_eq("wrap_full", 32'(cir_q_full), 32'd1);
    dr = 5'd25;
    step();
    issue = 1'b0;
    check_eq("wrap_full_hold", 32'(cir_q_full), 32'd1);

    // Complete the wrapped entries early so they retire after entry 31
    for (int k = 0; k < 5; k++) put(k, k, 220 + k);
    step();
    clr_bus();

    // Out-of-order completion
    for (int k = 0; k < 5; k++) put(k, o1[k], 200 + o1[k]);
    step();
    for (int k = 0; k < 5; k++) put(k, o2[k], 200 + o2[k]);
    step();
    clr_bus();
    repeat (12) step();

    // Completions scattered to the end of the buffer
    for (int k = 0; k < 5; k++) put(k, g1[k], 200 + g1[k]);
    step();
    for (int k = 0; k < 5; k++) put(k, g2[k], 200 + g2[k]);
    step();
    for (int k = 0; k < 5; k++) put(k, g3[k], 200 + g3[k]);
    step();
    clr_bus();
    for (int k = 0; k < 3; k++) put(k, g4[k], 200 + g4[k]);
    step();
    clr_bus();
    repeat (30) step();
    check_eq("end_empty", 32'(cir_q_empty), 32'd1);

    // Randomized traffic with occasional mid-operation reset
    for (int n = 0; n < 4000; n++) begin
      rst   = ($urandom_range(0, 299) != 0);
      issue = ((n / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      dr    = 5'($urandom_range(0, 31));
      for (int k = 0; k < 5; k++) begin
        bus[k].valid    = ($urandom_range(0, 1) == 1);
        bus[k].dest_rob = 5'($urandom_range(0, 31));
        bus[k].value    = $urandom;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
